// File: rtl/masked_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : masked_serial_adder_ctrl
// Summary  : Bit-serial first-order (2-share) masked ripple-carry adder.
//            One masked full-adder slice is reused for every bit position,
//            retiring one bit per accepted randomness beat.
// Options  : SHARE_ZEROIZE_EN - wipe operand/carry shares on DONE->IDLE and
//            wipe result shares one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module masked_serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B0,
  input  logic [WIDTH-1:0] B1,
  input  logic [1:0]       rnd,
  input  logic             rnd_valid,
  output logic             rnd_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum0,
  output logic [WIDTH-1:0] sum1,
  output logic             carry0,
  output logic             carry1
);

  localparam int IDXW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a0_q, a1_q, b0_q, b1_q;
  logic [IDXW-1:0]  idx;
  logic             c0, c1;
`ifdef SHARE_ZEROIZE_EN
  logic             zero_pending;
`endif

  // Masked full-adder slice for the current bit. Share 0 and share 1 only
  // meet inside the DOM cross-products, each re-masked by a fresh rnd bit.
  logic ai0, ai1, bi0, bi1;
  logic p0, p1, s0, s1;
  logic g0, g1, t0, t1;
  logic nc0, nc1;

  assign ai0 = a0_q[idx];
  assign ai1 = a1_q[idx];
  assign bi0 = b0_q[idx];
  assign bi1 = b1_q[idx];

  assign p0  = ai0 ^ bi0;
  assign p1  = ai1 ^ bi1;
  assign s0  = p0 ^ c0;
  assign s1  = p1 ^ c1;

  assign g0  = (ai0 & bi0) ^ (ai0 & bi1) ^ rnd[0];
  assign g1  = (ai1 & bi1) ^ (ai1 & bi0) ^ rnd[0];
  assign t0  = (p0 & c0) ^ (p0 & c1) ^ rnd[1];
  assign t1  = (p1 & c1) ^ (p1 & c0) ^ rnd[1];

  // Carry shares are registered below, so the two domains never recombine
  // combinationally across bit positions.
  assign nc0 = g0 ^ t0;
  assign nc1 = g1 ^ t1;

  // Control FSM plus all share-domain state; every output is registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rnd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum0      <= '0;
      sum1      <= '0;
      carry0    <= 1'b0;
      carry1    <= 1'b0;
      a0_q      <= '0;
      a1_q      <= '0;
      b0_q      <= '0;
      b1_q      <= '0;
      idx       <= '0;
      c0        <= 1'b0;
      c1        <= 1'b0;
`ifdef SHARE_ZEROIZE_EN
      zero_pending <= 1'b0;
`endif
    end else begin
`ifdef SHARE_ZEROIZE_EN
      // Results were available during the done cycle; scrub them now.
      if (zero_pending) begin
        sum0         <= '0;
        sum1         <= '0;
        carry0       <= 1'b0;
        carry1       <= 1'b0;
        zero_pending <= 1'b0;
      end
`endif
      case (state)
        ST_IDLE: begin
          if (start) begin
            a0_q      <= A0;
            a1_q      <= A1;
            b0_q      <= B0;
            b1_q      <= B1;
            idx       <= '0;
            c0        <= 1'b0;
            c1        <= 1'b0;
            rnd_ready <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Without fresh randomness nothing advances: a full stall.
          if (rnd_valid) begin
            sum0[idx] <= s0;
            sum1[idx] <= s1;
            c0        <= nc0;
            c1        <= nc1;
            if (idx == LAST_IDX) begin
              carry0    <= nc0;
              carry1    <= nc1;
              rnd_ready <= 1'b0;
              done      <= 1'b1;
              state     <= ST_DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
`ifdef SHARE_ZEROIZE_EN
          a0_q         <= '0;
          a1_q         <= '0;
          b0_q         <= '0;
          b1_q         <= '0;
          c0           <= 1'b0;
          c1           <= 1'b0;
          zero_pending <= 1'b1;
`endif
        end
        default: begin
          rnd_ready <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
